// File: rtl/mdr_load_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pkg_system_mdr
//  Description : Shared types and constants for the MDR input-side sequencer:
//                FSM state encoding, opcode decode values, demux selector
//                codes and the default data word width.
//  Revision    : 1.0 - initial release
// ============================================================================
package pkg_system_mdr;

    localparam int DDW_DEFAULT = 16;

    // Demux selector codes; the all-ones code is never driven.
    localparam int SEL_OP = 0;
    localparam int SEL_X  = 1;
    localparam int SEL_Y  = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_X    = 3'd1,
        WAIT_Y    = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIV  = 2'b01,
        OP_ROOT = 2'b10,
        OP_INV  = 2'b11
    } opcode_e;

endpackage
`default_nettype wire

// File: rtl/mdr_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : mdr_timeout_cnt
//  Description : Watchdog counter with synchronous clear and count enable.
//                Saturates at TIMEOUT-1 and flags expiry while there.
//  Ports       : clk       - rising-edge clock
//                rst       - synchronous active-high reset
//                i_clr     - clear count to zero
//                i_en      - advance count by one
//                o_expired - count has reached TIMEOUT-1
//  Revision    : 1.0 - initial release
// ============================================================================
module mdr_timeout_cnt #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int            CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != c_LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/mdr_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mdr_load_ctrl
//  Description : Input-side sequencer for the multiply/divide/root datapath.
//                Takes opcode, X and (except ROOT) Y words over valid/ready,
//                steers each into the demux with a one-cycle load strobe,
//                pulses start to the core and waits for done under a
//                watchdog. All outputs are registered.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_data/i_valid  - incoming word and its valid
//                o_ready         - word accepted on i_valid && o_ready
//                o_bus/o_sltr    - word and selector to the demux
//                o_load          - destination captures o_bus
//                o_start         - one-cycle start pulse to the core
//                i_done          - core finished (level or pulse)
//                o_busy          - opcode accepted, not yet back in IDLE
//                o_error         - sticky error (bad opcode, /0, timeout)
//  Revision    : 1.0 - initial release
// ============================================================================
module mdr_load_ctrl
    import pkg_system_mdr::*;
#(
    parameter int DDW     = DDW_DEFAULT,
    parameter int MUX_SEL = 2,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DDW-1:0]     i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [DDW-1:0]     o_bus,
    output logic [MUX_SEL-1:0] o_sltr,
    output logic               o_load,
    output logic               o_start,
    input  logic               i_done,
    output logic               o_busy,
    output logic               o_error
);

    state_e             r_state;
    opcode_e            r_op;
    logic               r_ready;
    logic [DDW-1:0]     r_bus;
    logic [MUX_SEL-1:0] r_sltr;
    logic               r_load;
    logic               r_start;
    logic               r_busy;
    logic               r_error;

    logic    w_xfer;
    opcode_e w_opc;
    logic    w_expired;

    assign w_xfer = i_valid && r_ready;
    assign w_opc  = opcode_e'(i_data[1:0]);

    // Counter is cleared while in START so it reads 0 on the o_start cycle.
    mdr_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (r_state == START),
        .i_en      (r_state == WAIT_DONE),
        .o_expired (w_expired)
    );

    // o_ready is registered, so it is set on every transition into (or
    // stay in) IDLE/WAIT_X/WAIT_Y and cleared on the move into START.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= OP_MUL;
            r_ready <= 1'b0;
            r_bus   <= '0;
            r_sltr  <= '0;
            r_load  <= 1'b0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_load  <= 1'b0;
            r_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_xfer) begin
                        if (w_opc == OP_INV) begin
                            r_error <= 1'b1;
                        end else begin
                            r_error <= 1'b0;
                            r_busy  <= 1'b1;
                            r_op    <= w_opc;
                            r_load  <= 1'b1;
                            r_sltr  <= MUX_SEL'(SEL_OP);
                            r_bus   <= i_data;
                            r_state <= WAIT_X;
                        end
                    end
                end
                WAIT_X: begin
                    if (w_xfer) begin
                        r_load <= 1'b1;
                        r_sltr <= MUX_SEL'(SEL_X);
                        r_bus  <= i_data;
                        if (r_op == OP_ROOT) begin
                            r_ready <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_state <= WAIT_Y;
                        end
                    end
                end
                WAIT_Y: begin
                    if (w_xfer) begin
                        if ((r_op == OP_DIV) && (i_data == '0)) begin
                            // Divide by zero: abort before loading Y.
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_load  <= 1'b1;
                            r_sltr  <= MUX_SEL'(SEL_Y);
                            r_bus   <= i_data;
                            r_ready <= 1'b0;
                            r_state <= START;
                        end
                    end
                end
                START: begin
                    r_start <= 1'b1;
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // Done takes priority over a simultaneous expiry.
                    if (i_done) begin
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_expired) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_bus   = r_bus;
    assign o_sltr  = r_sltr;
    assign o_load  = r_load;
    assign o_start = r_start;
    assign o_busy  = r_busy;
    assign o_error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_mdr_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdr_load_ctrl
//  Description : Self-checking bench for mdr_load_ctrl. Each vector holds the
//                inputs for one clock cycle and the registered outputs
//                expected just after that cycle's rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdr_load_ctrl;

    localparam int DDW     = 16;
    localparam int MUX_SEL = 2;
    localparam int TIMEOUT = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic [DDW-1:0]     i_data;
    logic               i_valid;
    logic               o_ready;
    logic [DDW-1:0]     o_bus;
    logic [MUX_SEL-1:0] o_sltr;
    logic               o_load;
    logic               o_start;
    logic               i_done;
    logic               o_busy;
    logic               o_error;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic           rst;
        logic           valid;
        logic [DDW-1:0] data;
        logic           done;
        logic           ready;
        logic           load;
        logic           start;
        logic           busy;
        logic           err;
        logic [1:0]     sltr;
        logic [DDW-1:0] bus;
    } vec_t;

    vec_t tbl[$];

    mdr_load_ctrl #(
        .DDW     (DDW),
        .MUX_SEL (MUX_SEL),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_bus   (o_bus),
        .o_sltr  (o_sltr),
        .o_load  (o_load),
        .o_start (o_start),
        .i_done  (i_done),
        .o_busy  (o_busy),
        .o_error (o_error)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic v, input logic [DDW-1:0] d,
                                input logic dn, input logic rdy, input logic ld,
                                input logic st, input logic bsy, input logic er,
                                input logic [1:0] sl, input logic [DDW-1:0] b);
        vec_t x;
        x.rst = r; x.valid = v; x.data = d; x.done = dn;
        x.ready = rdy; x.load = ld; x.start = st; x.busy = bsy; x.err = er;
        x.sltr = sl; x.bus = b;
        return x;
    endfunction

    task automatic apply(input vec_t v, input string name);
        rst     = v.rst;
        i_valid = v.valid;
        i_data  = v.data;
        i_done  = v.done;
        @(posedge clk);
        #1;
        n_checks++;
        if ({o_ready, o_load, o_start, o_busy, o_error, o_sltr, o_bus} !==
            {v.ready, v.load, v.start, v.busy, v.err, v.sltr, v.bus}) begin
            n_errors++;
            $display("FAIL %s: got rdy=%0b ld=%0b st=%0b bsy=%0b err=%0b sl=%0d bus=%h, required rdy=%0b ld=%0b st=%0b bsy=%0b err=%0b sl=%0d bus=%h",
                     name, o_ready, o_load, o_start, o_busy, o_error, o_sltr, o_bus,
                     v.ready, v.load, v.start, v.busy, v.err, v.sltr, v.bus);
        end
    endtask

    // Loads a full MUL (opcode 0, X, Y) from IDLE and checks the start pulse.
    task automatic mul_to_start(input logic [DDW-1:0] x, input logic [DDW-1:0] y,
                                input logic err_before, input string name);
        apply(mk(0, 1, 16'h0000, 0, 1, 1, 0, 1, 0, 2'd0, 16'h0000), {name, "_op"});
        apply(mk(0, 1, x,        0, 1, 1, 0, 1, 0, 2'd1, x),        {name, "_x"});
        apply(mk(0, 1, y,        0, 0, 1, 0, 1, 0, 2'd2, y),        {name, "_y"});
        apply(mk(0, 0, 16'h0000, 0, 0, 0, 1, 1, 0, 2'd2, y),        {name, "_start"});
        if (err_before) begin end
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_data = '0; i_done = 1'b0;

        // ---- reset and recovery ----
        tbl.push_back(mk(1, 1, 16'h0003, 0, 0, 0, 0, 0, 0, 2'd0, 16'h0000));
        tbl.push_back(mk(1, 1, 16'h0003, 0, 0, 0, 0, 0, 0, 2'd0, 16'h0000));
        tbl.push_back(mk(1, 1, 16'h0003, 0, 0, 0, 0, 0, 0, 2'd0, 16'h0000));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 2'd0, 16'h0000));
        // ---- MUL 0x0000, 0x0007, 0x0003 ----
        tbl.push_back(mk(0, 1, 16'h0000, 0, 1, 1, 0, 1, 0, 2'd0, 16'h0000));
        tbl.push_back(mk(0, 1, 16'h0007, 0, 1, 1, 0, 1, 0, 2'd1, 16'h0007));
        tbl.push_back(mk(0, 1, 16'h0003, 0, 0, 1, 0, 1, 0, 2'd2, 16'h0003));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 1, 1, 0, 2'd2, 16'h0003));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 2'd2, 16'h0003));
        tbl.push_back(mk(0, 1, 16'h0002, 0, 0, 0, 0, 1, 0, 2'd2, 16'h0003));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 2'd2, 16'h0003));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 2'd2, 16'h0003));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 2'd2, 16'h0003));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 0, 0, 0, 2'd2, 16'h0003));
        // ---- ROOT 0x0002, 0x0019 (extra word while not ready is ignored) ----
        tbl.push_back(mk(0, 1, 16'h0002, 0, 1, 1, 0, 1, 0, 2'd0, 16'h0002));
        tbl.push_back(mk(0, 1, 16'h0019, 0, 0, 1, 0, 1, 0, 2'd1, 16'h0019));
        tbl.push_back(mk(0, 1, 16'h0055, 0, 0, 0, 1, 1, 0, 2'd1, 16'h0019));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 0, 0, 0, 2'd1, 16'h0019));
        // ---- invalid opcode ----
        tbl.push_back(mk(0, 1, 16'h0003, 0, 1, 0, 0, 0, 1, 2'd1, 16'h0019));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 0, 0, 1, 2'd1, 16'h0019));
        // ---- DIV by zero, then MUL opcode clears error ----
        tbl.push_back(mk(0, 1, 16'h0001, 0, 1, 1, 0, 1, 0, 2'd0, 16'h0001));
        tbl.push_back(mk(0, 1, 16'h0010, 0, 1, 1, 0, 1, 0, 2'd1, 16'h0010));
        tbl.push_back(mk(0, 1, 16'h0000, 0, 1, 0, 0, 0, 1, 2'd1, 16'h0010));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 0, 0, 1, 2'd1, 16'h0010));
        tbl.push_back(mk(0, 1, 16'h0000, 0, 1, 1, 0, 1, 0, 2'd0, 16'h0000));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // ---- stall in WAIT_X for 10 cycles: nothing moves ----
        for (int i = 0; i < 10; i++) begin
            apply(mk(0, 0, 16'h0000, 0, 1, 0, 0, 1, 0, 2'd0, 16'h0000), $sformatf("stall%0d", i));
        end

        // ---- load X, then reset mid-operation with i_valid high ----
        apply(mk(0, 1, 16'h0007, 0, 1, 1, 0, 1, 0, 2'd1, 16'h0007), "midop_x");
        for (int i = 0; i < 3; i++) begin
            apply(mk(1, 1, 16'h0009, 0, 0, 0, 0, 0, 0, 2'd0, 16'h0000), $sformatf("midop_rst%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            apply(mk(0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 2'd0, 16'h0000), $sformatf("recover%0d", i));
        end

        // ---- watchdog expiry: no done, error exactly TIMEOUT after start ----
        mul_to_start(16'h0005, 16'h0006, 1'b0, "wd1");
        for (int k = 1; k < TIMEOUT; k++) begin
            apply(mk(0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 2'd2, 16'h0006), $sformatf("wd1_wait%0d", k));
        end
        apply(mk(0, 0, 16'h0000, 0, 1, 0, 0, 0, 1, 2'd2, 16'h0006), "wd1_expire");

        // ---- done on the expiry cycle: done wins, no error ----
        mul_to_start(16'h0004, 16'h0008, 1'b1, "wd2");
        for (int k = 1; k < TIMEOUT; k++) begin
            apply(mk(0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 2'd2, 16'h0008), $sformatf("wd2_wait%0d", k));
        end
        apply(mk(0, 0, 16'h0000, 1, 1, 0, 0, 0, 0, 2'd2, 16'h0008), "wd2_done_at_expiry");
        apply(mk(0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 2'd2, 16'h0008), "wd2_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdr_load_ctrl.md
Name: mdr_load_ctrl

Overview:
- Input-side sequencer for the multiply/divide/root (MDR) datapath.
- Accepts a stream of DDW-bit words over a valid/ready handshake and decodes the first word as an opcode.
- Drives a registered bus plus selector into the downstream 2^MUX_SEL-way demux that steers each word into the opcode, X and Y registers.
- Pulses start to the MDR core, then waits for done with a watchdog before returning to idle.

Parameters:
- DDW, 16: data word width; matches the demux bus width.
- MUX_SEL, 2: selector width; must be at least 2.
- TIMEOUT, 64: maximum cycles to wait for i_done after o_start.

Ports:
- clk  in  1: system clock; all logic is rising-edge.
- rst  in  1: synchronous, active-high reset.
- i_data  in  DDW: incoming word.
- i_valid  in  1: i_data is valid.
- o_ready  out  1: block can accept a word. A word transfers on a rising edge with i_valid && o_ready.
- o_bus  out  DDW: word presented to the demux.
- o_sltr  out  MUX_SEL: demux selector (0 = opcode, 1 = X, 2 = Y).
- o_load  out  1: one-cycle strobe; the destination register captures o_bus.
- o_start  out  1: one-cycle start pulse to the MDR core.
- i_done  in  1: MDR core finished; level or pulse accepted.
- o_busy  out  1: high from opcode acceptance until the return to IDLE.
- o_error  out  1: sticky error flag.

Behaviour:
- Reset, applied on the clock edge: every output is 0 and the state is IDLE. o_ready rises the cycle after rst deasserts. Reset mid-operation aborts with no pending o_start or o_load.
- All outputs are registered.
- o_ready = 1 only in IDLE, WAIT_X and WAIT_Y. It is 0 in all other states.
- Opcode: i_data[1:0]. 00 = MUL, 01 = DIV, 10 = ROOT, 11 = invalid.
- IDLE:
  - On transfer with a valid opcode: clear o_error, set o_busy, go to WAIT_X.
  - On transfer with an invalid opcode: set o_error, issue no o_load, stay in IDLE.
  - Next cycle after a valid opcode: o_load = 1, o_sltr = 0, o_bus = the word.
- WAIT_X:
  - On transfer: capture X. Next cycle: o_load = 1, o_sltr = 1, o_bus = X.
  - If ROOT, go to START; otherwise go to WAIT_Y.
- WAIT_Y:
  - On transfer with DIV and Y == 0: set o_error, issue no o_load for Y and no o_start, clear o_busy, go to IDLE.
  - Otherwise: next cycle o_load = 1, o_sltr = 2, o_bus = Y; go to START.
- START: o_start = 1 for exactly one cycle, on the cycle after the final o_load. Then go to WAIT_DONE and clear the watchdog counter.
- WAIT_DONE:
  - Counter increments each cycle.
  - i_done = 1: clear o_busy, go to IDLE.
  - Counter reaches TIMEOUT-1 without i_done: set o_error, clear o_busy, go to IDLE.
  - i_done in the same cycle as expiry: done wins and no error is raised.
- o_sltr never takes value 2^MUX_SEL-1; that demux output is unused.
- o_bus holds its last value when o_load = 0.
- o_error clears only on acceptance of a valid opcode, or on rst.
- i_valid while o_ready = 0 is ignored; the word is not consumed.

Decomposition:
- Package pkg_system_mdr holds:
  - state_e enum: IDLE, WAIT_X, WAIT_Y, START, WAIT_DONE.
  - opcode_e enum: OP_MUL, OP_DIV, OP_ROOT, OP_INV.
  - Selector constants SEL_OP = 0, SEL_X = 1, SEL_Y = 2.
  - Default DDW.
- One sub-module, mdr_timeout_cnt: clear/enable counter with an expiry flag, parameterised by TIMEOUT.

Test Plan:
- Reset, mid-operation abort, recovery:
  - Stimulus: assert rst for 3 cycles with i_valid = 1, including once after X is loaded; then issue a fresh opcode after release.
  - Required: all outputs 0 throughout rst; no o_start appears; o_ready = 1 one cycle after release; the fresh opcode is accepted normally.
- MUL: send 0x0000, 0x0007, 0x0003 back-to-back.
  - Required: o_load pulses with (sltr, bus) = (0, 0x0000), (1, 0x0007), (2, 0x0003).
  - Required: o_start exactly one cycle after the third o_load.
  - Required: i_done 5 cycles later drops o_busy; o_ready = 1 the next cycle.
- ROOT: send 0x0002, 0x0019.
  - Required: exactly two o_load pulses (sltr 0, 1), then o_start; no sltr = 2 pulse.
- DIV by zero: send 0x0001, 0x0010, 0x0000.
  - Required: o_error = 1, o_load only for sltr 0 and 1, no o_start, back to IDLE.
  - Then send 0x0000: o_error clears.
- Invalid opcode and stall:
  - Send 0x0003: o_error = 1, no o_load, stays in IDLE.
  - Hold i_valid low for 10 cycles in WAIT_X: no outputs change.
- Watchdog: MUL sequence, i_done never asserted.
  - Required: o_error = 1 and o_busy = 0 exactly TIMEOUT = 64 cycles after o_start.
  - Repeat with i_done on the expiry cycle: o_error stays 0.
